// File: rtl/pic_cmd_sequencer.sv
// pic_cmd_sequencer: decodes CPU command writes into the ICW1-ICW4
// initialization sequence and the OCW1-OCW3 operational commands, and holds
// the resulting configuration for the rest of the interrupt controller.
//
// Write interface: wr_en is a single-cycle strobe with no backpressure. Every
// cycle with wr_en=1 is one independent write of {a0, din}, and it is always
// accepted. All outputs are registered, so a write sampled at edge N appears
// on the outputs just after edge N.
module pic_cmd_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       init_done,
  output logic       ltim,
  output logic       sngl,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_cfg,
  output logic       aeoi,
  output logic [1:0] buf_ms,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic       eoi_cmd,
  output logic [2:0] eoi_rsl,
  output logic [2:0] eoi_level,
  output logic       read_isr,
  output logic       smm,
  output logic       poll_cmd
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ICW2 = 3'd1,
    W_ICW3 = 3'd2,
    W_ICW4 = 3'd3,
    READY  = 3'd4
  } state_t;

  state_t     state, state_next;
  logic       ic4, ic4_next;
  logic       ltim_next, sngl_next, aeoi_next, sfnm_next;
  logic       read_isr_next, smm_next, eoi_cmd_next, poll_cmd_next;
  logic [4:0] vector_base_next;
  logic [7:0] cascade_cfg_next, imr_next;
  logic [1:0] buf_ms_next;
  logic [2:0] eoi_rsl_next, eoi_level_next;

  // Write classes. ICW1 is recognised in every state; OCW2/OCW3 only
  // matter once the sequence has reached READY.
  logic is_icw1, is_data, is_ocw2, is_ocw3;
  assign is_icw1 = wr_en && !a0 && din[4];
  assign is_data = wr_en && a0;
  assign is_ocw2 = wr_en && !a0 && !din[4] && !din[3];
  assign is_ocw3 = wr_en && !a0 && !din[4] && din[3];

  // init_done is a decode of the registered state, so it rises on the same
  // edge the last required ICW is stored.
  assign init_done = (state == READY);

  // Next-state and next-register computation; every field holds by default
  // and the command pulses default low.
  always_comb begin
    state_next       = state;
    ic4_next         = ic4;
    ltim_next        = ltim;
    sngl_next        = sngl;
    vector_base_next = vector_base;
    cascade_cfg_next = cascade_cfg;
    aeoi_next        = aeoi;
    buf_ms_next      = buf_ms;
    sfnm_next        = sfnm;
    imr_next         = imr;
    eoi_cmd_next     = 1'b0;
    eoi_rsl_next     = eoi_rsl;
    eoi_level_next   = eoi_level;
    read_isr_next    = read_isr;
    smm_next         = smm;
    poll_cmd_next    = 1'b0;

    if (is_icw1) begin
      // Restart: anything a partial sequence already wrote to the cleared
      // fields is discarded here.
      ltim_next     = din[3];
      sngl_next     = din[1];
      ic4_next      = din[0];
      imr_next      = 8'h00;
      aeoi_next     = 1'b0;
      buf_ms_next   = 2'b00;
      sfnm_next     = 1'b0;
      smm_next      = 1'b0;
      read_isr_next = 1'b0;
      state_next    = W_ICW2;
    end else begin
      unique case (state)
        IDLE: begin
          // Not initialised: only ICW1 has any effect.
        end
        W_ICW2: begin
          if (is_data) begin
            vector_base_next = din[7:3];
            if (!sngl)    state_next = W_ICW3;
            else if (ic4) state_next = W_ICW4;
            else          state_next = READY;
          end
        end
        W_ICW3: begin
          if (is_data) begin
            cascade_cfg_next = din;
            state_next       = ic4 ? W_ICW4 : READY;
          end
        end
        W_ICW4: begin
          if (is_data) begin
            aeoi_next   = din[1];
            buf_ms_next = din[3:2];
            sfnm_next   = din[4];
            state_next  = READY;
          end
        end
        READY: begin
          if (is_data) begin
            imr_next = din;
          end else if (is_ocw2) begin
            eoi_cmd_next   = 1'b1;
            eoi_rsl_next   = din[7:5];
            eoi_level_next = din[2:0];
          end else if (is_ocw3) begin
            if (din[1]) read_isr_next = din[0];
            if (din[6]) smm_next      = din[5];
            poll_cmd_next = din[2];
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and configuration registers; reset wins over any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ic4         <= 1'b0;
      ltim        <= 1'b0;
      sngl        <= 1'b0;
      vector_base <= 5'd0;
      cascade_cfg <= 8'h00;
      aeoi        <= 1'b0;
      buf_ms      <= 2'b00;
      sfnm        <= 1'b0;
      imr         <= 8'h00;
      eoi_cmd     <= 1'b0;
      eoi_rsl     <= 3'd0;
      eoi_level   <= 3'd0;
      read_isr    <= 1'b0;
      smm         <= 1'b0;
      poll_cmd    <= 1'b0;
    end else begin
      state       <= state_next;
      ic4         <= ic4_next;
      ltim        <= ltim_next;
      sngl        <= sngl_next;
      vector_base <= vector_base_next;
      cascade_cfg <= cascade_cfg_next;
      aeoi        <= aeoi_next;
      buf_ms      <= buf_ms_next;
      sfnm        <= sfnm_next;
      imr         <= imr_next;
      eoi_cmd     <= eoi_cmd_next;
      eoi_rsl     <= eoi_rsl_next;
      eoi_level   <= eoi_level_next;
      read_isr    <= read_isr_next;
      smm         <= smm_next;
      poll_cmd    <= poll_cmd_next;
    end
  end

endmodule
